// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit front end for a synchronous block-RAM data memory
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned / size-11 requests complete with rsp_err=1 and no RAM access
//   undefined : rsp_err tied 0, size 11 acts as word, low address bits below the
//               access size are ignored
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           CPU request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata
//                                 store flag, size (00 byte, 01 half, 10 word, 11 illegal),
//                                 load extension mode, byte address, right-aligned store data
//   rsp_valid, rsp_rdata, rsp_err one-cycle completion pulse, extended load data, error
//   mem_addr, mem_en, mem_we, mem_din, mem_dout
//                                 word-addressed synchronous RAM port
module lsu_mem_ctrl #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  acc_size;
  logic        req_bad;

`ifdef LSU_ALIGN_CHECK_EN
  assign acc_size = req_size;
  assign req_bad  = (req_size == 2'b11) ||
                    (req_size == SZ_HALF && req_addr[0]) ||
                    (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  // Illegal size degrades to a word access; misalignment is absorbed by lane selection.
  assign acc_size = (req_size == 2'b11) ? SZ_WORD : req_size;
  assign req_bad  = 1'b0;
`endif

  // Pick the addressed byte/half from a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: load_ext = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = acc_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (req_bad) begin
            state_d = S_RESP;
            rdata_d = '0;
          end else if (req_we && acc_size == SZ_WORD) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        mem_en  = 1'b1;
        cnt_d   = 3'(RD_LATENCY);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          word_d = mem_dout;
          if (we_q) begin
            state_d = S_WR;
          end else begin
            state_d = S_RESP;
            rdata_d = load_ext(mem_dout, size_q, addr_q[1:0], uns_q);
          end
        end
      end
      S_WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        rdata_d = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write data is always derived from the latched request so it stays stable
  // outside WR; sub-word stores merge into the word fetched during RD_WAIT.
  always_comb begin
    mem_din = word_q;
    case (size_q)
      SZ_BYTE: mem_din[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: mem_din[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: mem_din = wdata_q;
    endcase
  end

  assign mem_addr  = {2'b00, addr_q[31:2]};
  assign rsp_rdata = rdata_q;

`ifdef LSU_ALIGN_CHECK_EN
  // Only the IDLE->RESP shortcut is an error; every other path into RESP clears it.
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q != S_RESP && state_d == S_RESP) begin
      err_q <= (state_q == S_IDLE);
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

- Initiator side of the data-memory port: accepts byte/halfword/word load and store requests from the CPU's memory stage and drives the synchronous block-RAM data-memory interface (`mem_addr`, `mem_en`, `mem_we`, `mem_din`, `mem_dout`).
- Converts byte addresses to word addresses and hides the RAM read latency behind a valid/ready handshake.
- Performs sub-word stores as read-modify-write, sign- or zero-extends loads, and flags misaligned accesses.

## Interface
Parameters:
- `RD_LATENCY`, default 1: clock edges from the address-sampling edge until `mem_dout` is valid (1..4).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  encoding: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  zero-extend loads when 1, sign-extend when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal-size request; qualified by `rsp_valid`.
- `mem_addr`  out  32  word address, `{2'b00, addr_q[31:2]}`.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  1  RAM write enable.
- `mem_din`  out  32  RAM write data.
- `mem_dout`  in  32  RAM read data.

## Operation
- States are IDLE, RD, RD_WAIT, WR, RESP. `mem_*` and `req_ready` are decoded combinationally from the registered state and the latched request.
- **IDLE**
  - `req_ready=1`, `mem_en=0`.
  - On `req_valid&&req_ready`, latch addr, size, we, unsigned and wdata, then branch:
    - misaligned (half with `addr[0]`≠0, word with `addr[1:0]`≠0) or size 11 → RESP with error;
    - word store → WR;
    - otherwise → RD.
- **RD**
  - `mem_en=1`, `mem_we=0`.
  - Go to RD_WAIT and load the wait counter with `RD_LATENCY`.
- **RD_WAIT**
  - `mem_en=0`; decrement the counter each cycle.
  - When it reaches 1, sample `mem_dout` into the data register, then:
    - load → RESP;
    - sub-word store → WR.
- **WR**
  - `mem_en=1`, `mem_we=1`.
  - `mem_din` is the full `wdata` for a word store.
  - For a sub-word store, `mem_din` is the sampled word with its selected lanes replaced. Byte lane k is bits `[8k+7:8k]`, k = `addr[1:0]`; a half-word uses lanes `2*addr[1]` and `2*addr[1]+1` (little-endian).
  - Go to RESP.
- **RESP**
  - `rsp_valid=1` for exactly one cycle, then IDLE.
- **Load extraction**: select the byte or half by address lane, then extend per `req_unsigned`.
- `rsp_rdata` and `rsp_err` are registered and hold until the next RESP.
- `mem_addr` and `mem_din` are don't-care when `mem_en=0`, but are kept stable from the latched request.
- **Reset values**: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_din=0`.
- **Reset mid-operation**: state returns to IDLE immediately, the in-flight request is dropped, and no `rsp_valid` is produced. A WR cycle already sampled by the RAM is not undone.
- Requests are ignored while `rst`=1.

## Timing
- Cycle 0 is the accept cycle (`req_valid&&req_ready`). Responses arrive as follows (`rsp_valid` high):
  - Load: cycle `2+RD_LATENCY` (3 at default).
  - Word store: cycle 2; RAM write occurs on the cycle-1 edge.
  - Sub-word store: cycle `3+RD_LATENCY` (4 at default); RAM write in cycle `2+RD_LATENCY`.
  - Error: cycle 1; no RAM access.
- `req_ready` is low from cycle 1 until the cycle after RESP. The earliest next accept is the cycle after `rsp_valid`, and there is at most one outstanding request.
- `req_*` inputs are required stable only in the accept cycle.

## Configuration
- **`LSU_ALIGN_CHECK_EN` defined**: misaligned and illegal-size requests produce `rsp_err=1` with no memory access.
- **`LSU_ALIGN_CHECK_EN` undefined**:
  - `rsp_err` is tied to 0.
  - Size 11 is treated as word.
  - Address low bits below the access size are ignored (half uses `addr[1]` only; word ignores `addr[1:0]`).
  - Such requests proceed as normal aligned accesses.

## Test plan
Bench uses a 1-cycle RAM model, `RD_LATENCY=1`.
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → `rsp_rdata=0xDEADBEEF`; store `rsp_valid` in cycle 2, load `rsp_valid` in cycle 3.
- Byte loads: with word[4]=0x80FF7F01, signed byte load 0x13 → 0xFFFFFF80; unsigned byte 0x12 → 0x000000FF; signed half 0x12 → 0xFFFF80FF.
- Byte store 0xAB to 0x11 over 0x11223344 → RAM word becomes 0x1122AB44; exactly one read then one write; `rsp_valid` in cycle 4.
- Half load at 0x03 with `LSU_ALIGN_CHECK_EN` → `rsp_err=1`, `rsp_rdata=0`, `mem_en` never high, `rsp_valid` in cycle 1. Without the macro → returns the half at lanes 2..3 of word 0, `rsp_err=0`.
- Assert `rst` in RD_WAIT of a load → `mem_en=0`, `rsp_valid` never pulses, `req_ready=1` after release; the next word load completes normally.
- Back-to-back: hold `req_valid` for three loads → accepts are spaced 4 cycles apart (RESP, then IDLE accept); each response matches its address.
